// File: rtl/rob_recovery_ctrl_if.sv
// Bundle between the misprediction recovery controller and its surroundings:
// requester, ROB walk read port, map table, free list, ROB rollback and fetch.
interface rob_recovery_ctrl_if #(
  parameter int ROB_SIZE = 32,
  parameter int PRF_SIZE = 64,
  parameter int RF_SIZE  = 32,
  parameter int WIDTH    = 2,
  parameter int XLEN     = 32
);
  localparam int IW = $clog2(ROB_SIZE);
  localparam int PW = $clog2(PRF_SIZE);
  localparam int AW = $clog2(RF_SIZE);

  logic                         mispredict_req;
  logic [IW-1:0]                mispredict_idx;
  logic [XLEN-1:0]              mispredict_pc;
  logic [IW-1:0]                rob_tail;
  logic                         mispredict_ack;
  logic [WIDTH-1:0][IW-1:0]     walk_idx;
  logic [WIDTH-1:0]             walk_valid;
  logic [WIDTH-1:0][AW-1:0]     walk_rd;
  logic [WIDTH-1:0][PW-1:0]     walk_T;
  logic [WIDTH-1:0][PW-1:0]     walk_T_old;
  logic [WIDTH-1:0]             map_restore_en;
  logic [WIDTH-1:0][AW-1:0]     map_restore_rd;
  logic [WIDTH-1:0][PW-1:0]     map_restore_T_old;
  logic [WIDTH-1:0]             freelist_return_en;
  logic [WIDTH-1:0][PW-1:0]     freelist_return_T;
  logic                         rollback_en;
  logic [IW-1:0]                recover_head;
  logic                         fetch_redirect_en;
  logic [XLEN-1:0]              fetch_redirect_pc;
  logic                         dispatch_stall;
  logic                         busy;

  modport master (
    output mispredict_req, mispredict_idx, mispredict_pc, rob_tail,
           walk_valid, walk_rd, walk_T, walk_T_old,
    input  mispredict_ack, walk_idx, map_restore_en, map_restore_rd, map_restore_T_old,
           freelist_return_en, freelist_return_T, rollback_en, recover_head,
           fetch_redirect_en, fetch_redirect_pc, dispatch_stall, busy
  );

  modport slave (
    input  mispredict_req, mispredict_idx, mispredict_pc, rob_tail,
           walk_valid, walk_rd, walk_T, walk_T_old,
    output mispredict_ack, walk_idx, map_restore_en, map_restore_rd, map_restore_T_old,
           freelist_return_en, freelist_return_T, rollback_en, recover_head,
           fetch_redirect_en, fetch_redirect_pc, dispatch_stall, busy
  );
endinterface

// File: rtl/rob_recovery_ctrl.sv
// Misprediction recovery sequencer: walks the ROB youngest-first undoing renames,
// then truncates the ROB and redirects fetch while holding dispatch stalled.
module rob_recovery_ctrl #(
  parameter int ROB_SIZE = 32,
  parameter int PRF_SIZE = 64,
  parameter int RF_SIZE  = 32,
  parameter int WIDTH    = 2,
  parameter int XLEN     = 32
) (
  input logic                clock_i,
  input logic                reset_ni,
  rob_recovery_ctrl_if.slave rcv_if
);
  localparam int IW = $clog2(ROB_SIZE);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WALK     = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   cursor_q, cursor_d;
  logic [IW:0]     remaining_q, remaining_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] lane_act_s;
  logic [IW:0]      n_s;

  // A lane is live only while fewer than `remaining` entries precede it in this cycle.
  always_comb begin
    n_s = (IW+1)'(0);
    for (int i = 0; i < WIDTH; i++) begin
      lane_act_s[i] = (state_q == S_WALK) && ((IW+1)'(i) < remaining_q);
      if (lane_act_s[i]) begin
        n_s = n_s + (IW+1)'(1);
      end else begin
        n_s = n_s;
      end
    end
  end

  // Next-state and datapath update for the recovery sequence.
  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    pc_d        = pc_q;
    case (state_q)
      S_IDLE: begin
        if (rcv_if.mispredict_req) begin
          idx_d       = rcv_if.mispredict_idx;
          pc_d        = rcv_if.mispredict_pc;
          cursor_d    = rcv_if.rob_tail - IW'(1);
          remaining_d = {1'b0, IW'(rcv_if.rob_tail - rcv_if.mispredict_idx - IW'(1))};
          state_d     = (remaining_d != (IW+1)'(0)) ? S_WALK : S_COMMIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WALK: begin
        cursor_d    = cursor_q - IW'(n_s);
        remaining_d = remaining_q - n_s;
        if (remaining_d == (IW+1)'(0)) begin
          state_d = S_COMMIT;
        end else begin
          state_d = S_WALK;
        end
      end
      S_COMMIT:   state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State registers; an asynchronous reset abandons any walk in progress.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      cursor_q    <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      pc_q        <= '0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      pc_q        <= pc_d;
    end
  end

  // Output decode; lane 0 is youngest, the map table resolves same-rd writes to the higher lane.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      rcv_if.walk_idx[i]           = (state_q == S_WALK) ? (cursor_q - IW'(i)) : IW'(0);
      rcv_if.map_restore_en[i]     = lane_act_s[i] & rcv_if.walk_valid[i];
      rcv_if.freelist_return_en[i] = lane_act_s[i] & rcv_if.walk_valid[i];
      rcv_if.map_restore_rd[i]     = rcv_if.walk_rd[i];
      rcv_if.map_restore_T_old[i]  = rcv_if.walk_T_old[i];
      rcv_if.freelist_return_T[i]  = rcv_if.walk_T[i];
    end
    rcv_if.mispredict_ack    = rcv_if.mispredict_req && (state_q == S_IDLE);
    rcv_if.busy              = (state_q != S_IDLE);
    rcv_if.dispatch_stall    = (state_q != S_IDLE) || rcv_if.mispredict_req;
    rcv_if.rollback_en       = (state_q == S_COMMIT);
    rcv_if.recover_head      = (state_q == S_COMMIT) ? (idx_q + IW'(1)) : IW'(0);
    rcv_if.fetch_redirect_en = (state_q == S_REDIRECT);
    rcv_if.fetch_redirect_pc = (state_q == S_REDIRECT) ? pc_q : XLEN'(0);
  end
endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Directed bench for rob_recovery_ctrl: table of recovery scenarios plus hand
// sequences for invalid/duplicate lanes, ignored mid-walk requests and reset abort.
module tb_rob_recovery_ctrl;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] rob_valid;
  logic        dup_rd;

  rob_recovery_ctrl_if rif();

  rob_recovery_ctrl dut (
    .clock_i (clk),
    .reset_ni(rst_n),
    .rcv_if  (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROB read model: T_old = {0,index}, T = {1,index}, rd = index unless forced.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rif.walk_valid[i] = rob_valid[rif.walk_idx[i]];
      rif.walk_rd[i]    = dup_rd ? 5'd3 : rif.walk_idx[i];
      rif.walk_T[i]     = {1'b1, rif.walk_idx[i]};
      rif.walk_T_old[i] = {1'b0, rif.walk_idx[i]};
    end
  end

  typedef struct {
    logic [4:0]  tail;
    logic [4:0]  idx;
    logic [31:0] pc;
    int          walks;
    int          restores;
    logic [4:0]  head;
    logic [4:0]  f0, f1, l0, l1;
    logic [1:0]  last_en;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_mask(input logic [4:0] tail, input logic [4:0] idx,
                                           input logic [31:0] valid);
    logic [4:0] n;
    logic [4:0] k;
    exp_mask = 32'd0;
    n = tail - idx - 5'd1;
    for (int j = 1; j <= int'(n); j++) begin
      k = idx + 5'(j);
      exp_mask[k] = valid[k];
    end
  endfunction

  task automatic start_req(input logic [4:0] tail, input logic [4:0] idx, input logic [31:0] pc,
                           input string tag);
    @(posedge clk); #1;
    rif.mispredict_req = 1'b1;
    rif.rob_tail       = tail;
    rif.mispredict_idx = idx;
    rif.mispredict_pc  = pc;
    @(negedge clk);
    chk({tag, " ack"}, rif.mispredict_ack, 1);
    chk({tag, " stall_req"}, rif.dispatch_stall, 1);
    chk({tag, " busy_req"}, rif.busy, 0);
    @(posedge clk); #1;
    rif.mispredict_req = 1'b0;
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    string tag;
    int busy_cyc, walk_cyc, rb_cyc, rd_cyc, restores, stall_bad;
    logic [31:0] rmask, fmask, rpc;
    logic [4:0]  head;
    logic [9:0]  first_pair, last_pair;
    logic [1:0]  last_en;
    bit done;
    v = vecs[vi];
    tag = $sformatf("v%0d", vi);
    busy_cyc = 0; walk_cyc = 0; rb_cyc = -1; rd_cyc = -1; restores = 0; stall_bad = 0;
    rmask = 32'd0; fmask = 32'd0; rpc = 32'd0; head = 5'd0;
    first_pair = 10'd0; last_pair = 10'd0; last_en = 2'd0; done = 1'b0;
    start_req(v.tail, v.idx, v.pc, tag);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!rif.busy) begin
        done = 1'b1;
      end else begin
        busy_cyc++;
        if (!rif.dispatch_stall) stall_bad++;
        if (rif.rollback_en) begin
          rb_cyc = c;
          head = rif.recover_head;
        end else if (rb_cyc < 0 && rd_cyc < 0) begin
          walk_cyc++;
          if (walk_cyc == 1) first_pair = rif.walk_idx;
          last_pair = rif.walk_idx;
          last_en = rif.map_restore_en;
        end
        if (rif.fetch_redirect_en) begin
          rd_cyc = c;
          rpc = rif.fetch_redirect_pc;
        end
        for (int i = 0; i < 2; i++) begin
          if (rif.map_restore_en[i]) begin
            restores++;
            rmask[rif.map_restore_T_old[i][4:0]] = 1'b1;
          end
          if (rif.freelist_return_en[i] && rif.freelist_return_T[i][5])
            fmask[rif.freelist_return_T[i][4:0]] = 1'b1;
        end
      end
    end
    chk({tag, " timeout"}, done, 1);
    chk({tag, " busy_cycles"}, busy_cyc, v.walks + 2);
    chk({tag, " walk_cycles"}, walk_cyc, v.walks);
    chk({tag, " restores"}, restores, v.restores);
    chk({tag, " restore_mask"}, rmask, exp_mask(v.tail, v.idx, 32'hFFFF_FFFF));
    chk({tag, " free_mask"}, fmask, exp_mask(v.tail, v.idx, 32'hFFFF_FFFF));
    chk({tag, " head"}, head, v.head);
    chk({tag, " rollback_cycle"}, rb_cyc, v.walks);
    chk({tag, " redirect_cycle"}, rd_cyc, v.walks + 1);
    chk({tag, " redirect_pc"}, rpc, v.pc);
    chk({tag, " stall_busy"}, stall_bad, 0);
    if (v.walks > 0) begin
      chk({tag, " first_walk"}, first_pair, {v.f1, v.f0});
      chk({tag, " last_walk"}, last_pair, {v.l1, v.l0});
      chk({tag, " last_en"}, last_en, v.last_en);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int restores;
    bit seen;
    int bad;
    vecs[0] = '{5'd10, 5'd5,  32'h400,  2,  4,  5'd6,  5'd9,  5'd8,  5'd7,  5'd6,  2'b11};
    vecs[1] = '{5'd6,  5'd5,  32'h1234, 0,  0,  5'd6,  5'd0,  5'd0,  5'd0,  5'd0,  2'b00};
    vecs[2] = '{5'd2,  5'd29, 32'h8000, 2,  4,  5'd30, 5'd1,  5'd0,  5'd31, 5'd30, 2'b11};
    vecs[3] = '{5'd9,  5'd5,  32'h500,  2,  3,  5'd6,  5'd8,  5'd7,  5'd6,  5'd5,  2'b01};
    vecs[4] = '{5'd0,  5'd31, 32'h600,  0,  0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  2'b00};
    vecs[5] = '{5'd12, 5'd12, 32'h700,  16, 31, 5'd13, 5'd11, 5'd10, 5'd13, 5'd12, 2'b01};

    rob_valid = 32'hFFFF_FFFF;
    dup_rd = 1'b0;
    rif.mispredict_req = 1'b0;
    rif.mispredict_idx = 5'd0;
    rif.mispredict_pc  = 32'd0;
    rif.rob_tail       = 5'd0;
    rst_n = 1'b0;
    #23;
    chk("rst busy", rif.busy, 0);
    chk("rst stall", rif.dispatch_stall, 0);
    chk("rst ack", rif.mispredict_ack, 0);
    chk("rst enables", {rif.map_restore_en, rif.freelist_return_en, rif.rollback_en,
                        rif.fetch_redirect_en}, 0);
    chk("rst outputs", {rif.recover_head, rif.fetch_redirect_pc, rif.walk_idx}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int vi = 0; vi < 6; vi++) run_vec(vi);

    // Lane 1 invalid on the first walk cycle, all rd equal, plus an ignored second request.
    rob_valid = 32'hFFFF_FEFF;
    dup_rd = 1'b1;
    start_req(5'd10, 5'd5, 32'h400, "dup");
    rif.mispredict_req = 1'b1;
    rif.mispredict_idx = 5'd0;
    rif.rob_tail       = 5'd20;
    rif.mispredict_pc  = 32'hBAD;
    @(negedge clk);
    chk("dup ack_ignored", rif.mispredict_ack, 0);
    chk("dup stall", rif.dispatch_stall, 1);
    chk("dup map_en", rif.map_restore_en, 2'b01);
    chk("dup free_en", rif.freelist_return_en, 2'b01);
    chk("dup rd", rif.map_restore_rd[0], 5'd3);
    chk("dup T_old", rif.map_restore_T_old[0], 6'd9);
    restores = 1;
    @(posedge clk); #1;
    rif.mispredict_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (rif.map_restore_en[i]) restores++;
      if (rif.fetch_redirect_en) begin
        seen = 1'b1;
        chk("dup redirect_pc", rif.fetch_redirect_pc, 32'h400);
      end
    end
    chk("dup redirect_seen", seen, 1);
    chk("dup restores", restores, 3);
    @(negedge clk);
    chk("dup idle", rif.busy, 0);
    rob_valid = 32'hFFFF_FFFF;
    dup_rd = 1'b0;

    // Full ROB walk interrupted by reset in its third walk cycle.
    start_req(5'd12, 5'd12, 32'h900, "full");
    @(negedge clk);
    chk("full walk1", rif.walk_idx, {5'd10, 5'd11});
    chk("full en1", rif.map_restore_en, 2'b11);
    @(posedge clk);
    @(posedge clk); #1;
    chk("full busy_pre", rif.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("full rst busy", rif.busy, 0);
    chk("full rst enables", {rif.map_restore_en, rif.freelist_return_en, rif.rollback_en,
                             rif.fetch_redirect_en}, 0);
    chk("full rst stall", rif.dispatch_stall, 0);
    chk("full rst walk_idx", rif.walk_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rif.busy || (rif.map_restore_en != 2'b00) || rif.rollback_en) bad++;
    end
    chk("full post_rst_quiet", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
